lsu: RTL and testbench
======================

# lsu

Load/store unit for the 2-stage RISC-V core, directly downstream of the execute stage. It takes the ALU result as the effective address and Rd2 as store data, then runs one data-memory transaction over a req/gnt/rvalid bus. While the access is in flight it stalls the pipeline. It returns sign- or zero-extended load data for register writeback.

## Interface
Parameters:
- `WIDTH`, default 32: data and address width. Only 32 is supported.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state updates on rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `ls_req`  in  1  execute stage holds a load/store (level, held while stalled)
- `ls_we`  in  1  1 = store, 0 = load
- `ls_funct3`  in  3  RISC-V funct3 of the access
- `alu_result`  in  32  effective address from exe
- `Rd2`  in  32  store data from register file
- `ls_stall`  out  1  freeze pipeline
- `ls_done`  out  1  one-cycle pulse: access complete
- `rdata_out`  out  32  extended load result
- `ls_misaligned`  out  1  misaligned-access trap (macro only)
- `dmem_req`  out  1  bus request
- `dmem_we`  out  1  bus write
- `dmem_be`  out  4  byte enables
- `dmem_addr`  out  32  word-aligned address (bits [1:0] = 0)
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_gnt`  in  1  request accepted
- `dmem_rvalid`  in  1  response; asserted for loads and stores
- `dmem_rdata`  in  32  load data word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ on `ls_req` with an aligned (or non-trapping) access. In that cycle, register addr, we, funct3, be and wdata.
  - REQ → WAIT on `dmem_gnt`. Otherwise stay in REQ with all bus outputs held stable.
  - WAIT → DONE on `dmem_rvalid`. For loads, format `dmem_rdata` and register it into `rdata_out`.
  - DONE → IDLE unconditionally. `ls_req` in DONE belongs to the retiring instruction and is ignored.
- `ls_stall` = (IDLE & `ls_req` & accepted) | REQ | WAIT. It is low in DONE.
- `ls_done` = 1 only in DONE.
- funct3 mapping:
  - 000 = B
  - 001 = H
  - 010 = W
  - 100 = BU
  - 101 = HU
  - 011/110/111 = treated as W.
- Byte enables:
  - B: 4'b0001 << addr[1:0]
  - H: 4'b0011 << {addr[1],1'b0}
  - W: 4'b1111
- Store data replication:
  - B: {4{Rd2[7:0]}}
  - H: {2{Rd2[15:0]}}
  - W: Rd2
- Load extraction uses the selected byte/half lane, then sign-extends (B/H) or zero-extends (BU/HU).
- Stores leave `rdata_out` unchanged. It holds its value until the next load completes.
- Misalignment means H with addr[0]=1, or W with addr[1:0]≠0. Without the macro, the offending low bits are truncated to zero.

## Timing
- Registered outputs reset to 0: `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata`, `rdata_out`, `ls_done`. State resets to IDLE.
- `dmem_req` is high exactly in REQ and low in WAIT. At most one outstanding transaction.
- `dmem_rvalid` is sampled only in WAIT. It is ignored in IDLE/REQ/DONE, including stray responses after reset.
- Minimum latency (gnt in the REQ cycle, rvalid the next cycle):
  - accept cycle 0, REQ 1, WAIT 2, DONE 3.
  - `ls_stall` is high for cycles 0–2.
- Reset asserted mid-transaction aborts it: IDLE on the next edge, `dmem_req` deasserted.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access in IDLE issues no bus request.
  - `ls_misaligned` asserts combinationally for that cycle, with `ls_stall` low. The FSM stays IDLE.
- Undefined:
  - `ls_misaligned` is tied 0.
  - Misaligned accesses proceed with truncated alignment.

## Structure
- Shared package `rv_pkg`: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the LSU state enum.
- Sub-module `ls_align` (combinational): byte-enable generation, store replication and load extraction/extension. The FSM and registers stay in `lsu`.

## Test plan
- SW addr 0x100, Rd2 0xDEADBEEF, gnt immediate, rvalid next cycle → be 4'b1111, addr 0x100, wdata 0xDEADBEEF; `ls_stall` 3 cycles; `ls_done` cycle 3.
- LB addr 0x103, rdata 0x80112233 → `rdata_out` 0xFFFFFF80. LBU same → 0x00000080.
- SH addr 0x102, Rd2 0x0000ABCD → be 4'b1100, wdata 0xABCDABCD. LHU addr 0x102, rdata 0xABCD1234 → 0x0000ABCD.
- Gnt withheld 3 cycles, rvalid 2 cycles later → bus outputs stable through REQ; `ls_stall` high until DONE; exactly one `ls_done`.
- LW addr 0x101:
  - with the macro → `ls_misaligned`=1, no `dmem_req`, `ls_stall`=0.
  - without → dmem_addr 0x100, normal completion.
- `rstn` low during WAIT, rvalid arrives after release → FSM IDLE, no `ls_done`, `rdata_out` 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core definitions: funct3 encodings, LSU state and access size.
// Imported by lsu and ls_align.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } ls_size_t;

    // Reserved encodings fall through to a full-word access
    function automatic ls_size_t f3_size(input logic [2:0] f3);
        ls_size_t sz;
        unique case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ls_align.sv
// Lane logic for the LSU: byte enables, store replication,
// and load lane extraction with sign/zero extension.
module ls_align
    import rv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        unique case (f3_size(st_funct3))
            SZ_B: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << {st_off[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

    // funct3[2] selects the unsigned variants
    always_comb begin
        ld_data = ld_word;
        unique case (f3_size(ld_funct3))
            SZ_B: ld_data = ld_funct3[2] ? {24'b0, ld_byte}
                                         : {{24{ld_byte[7]}}, ld_byte};
            SZ_H: ld_data = ld_funct3[2] ? {16'b0, ld_half}
                                         : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory access per instruction.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating.
module lsu
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [2:0]       ls_funct3,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] Rd2,
    output logic             ls_stall,
    output logic             ls_done,
    output logic [WIDTH-1:0] rdata_out,
    output logic             ls_misaligned,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [WIDTH-1:0] dmem_rdata
);

    lsu_state_t       state, state_nx;
    logic             accept;
    logic             trap;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [3:0]       be_nx;
    logic [WIDTH-1:0] wdata_nx;
    logic [WIDTH-1:0] ld_data;

    ls_align u_align (
        .st_funct3 (ls_funct3),
        .st_off    (alu_result[1:0]),
        .st_data   (Rd2),
        .st_be     (be_nx),
        .st_wdata  (wdata_nx),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_word   (dmem_rdata),
        .ld_data   (ld_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    always_comb begin
        unique case (f3_size(ls_funct3))
            SZ_H:    mis = alu_result[0];
            SZ_W:    mis = |alu_result[1:0];
            default: mis = 1'b0;
        endcase
    end
    assign trap          = mis;
    assign ls_misaligned = (state == IDLE) && ls_req && mis;
`else
    assign trap          = 1'b0;
    assign ls_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ls_req && !trap) begin
                    accept   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ:  if (dmem_gnt) state_nx = WAIT;
            WAIT: if (dmem_rvalid) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        ls_stall = accept || (state == REQ) || (state == WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            rdata_out  <= '0;
            ls_done    <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
        end else begin
            ls_done <= (state == WAIT) && dmem_rvalid;
            if (accept) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ls_we;
                dmem_be    <= be_nx;
                dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
                dmem_wdata <= wdata_nx;
                funct3_q   <= ls_funct3;
                off_q      <= alu_result[1:0];
            end else if ((state == REQ) && dmem_gnt) begin
                dmem_req <= 1'b0;
            end
            if ((state == WAIT) && dmem_rvalid && !dmem_we)
                rdata_out <= ld_data;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: stores, loads, bus stalls, reset abort
// and the misaligned-access behaviour of the current build.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] alu_result;
    logic [31:0] Rd2;
    logic        ls_stall;
    logic        ls_done;
    logic [31:0] rdata_out;
    logic        ls_misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ls_req        (ls_req),
        .ls_we         (ls_we),
        .ls_funct3     (ls_funct3),
        .alu_result    (alu_result),
        .Rd2           (Rd2),
        .ls_stall      (ls_stall),
        .ls_done       (ls_done),
        .rdata_out     (rdata_out),
        .ls_misaligned (ls_misaligned),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_be       (dmem_be),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access against a memory that grants after gnt_wait REQ
    // cycles and responds rv_wait cycles into WAIT.
    task automatic do_access(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] data,
        input  logic [31:0] rword,
        input  int          gnt_wait,
        input  int          rv_wait,
        output int          stall_n,
        output int          done_n,
        output int          done_at,
        output logic [3:0]  be_c,
        output logic [31:0] addr_c,
        output logic [31:0] wdata_c,
        output logic        we_c,
        output logic        stable
    );
        int  reqc;
        int  wc;
        bit  granted;
        bit  captured;
        stall_n = 0; done_n = 0; done_at = -1;
        be_c = '0; addr_c = '0; wdata_c = '0; we_c = 1'b0;
        stable = 1'b1;
        reqc = 0; wc = 0; granted = 0; captured = 0;
        ls_req = 1'b1; ls_we = we; ls_funct3 = f3;
        alu_result = addr; Rd2 = data; dmem_rdata = rword;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ls_stall) stall_n++;
            if (ls_done) begin
                done_n++;
                if (done_at < 0) done_at = c;
                ls_req = 1'b0;
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (dmem_req) begin
                if (!captured) begin
                    be_c = dmem_be; addr_c = dmem_addr;
                    wdata_c = dmem_wdata; we_c = dmem_we;
                    captured = 1;
                end else if (dmem_be !== be_c || dmem_addr !== addr_c ||
                             dmem_wdata !== wdata_c || dmem_we !== we_c) begin
                    stable = 1'b0;
                end
                if (reqc == gnt_wait) begin
                    dmem_gnt = 1'b1;
                    granted = 1;
                    wc = 0;
                end
                reqc++;
            end else if (granted) begin
                if (wc == rv_wait) begin
                    dmem_rvalid = 1'b1;
                    granted = 0;
                end
                wc++;
            end
            if (done_at >= 0 && c == done_at + 1) break;
            @(posedge clk);
        end
        ls_req = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        dmem_rvalid = 1'b1;
        step(); step();
        total_cnt++;
        if (dmem_req !== 1'b0 || ls_done !== 1'b0 || ls_stall !== 1'b0 ||
            rdata_out !== 32'h0 || dmem_be !== 4'h0 || dmem_addr !== 32'h0 ||
            dmem_wdata !== 32'h0 || dmem_we !== 1'b0) begin
            $display("FAIL reset_outputs: req=%b done=%b stall=%b rdata=%h be=%h addr=%h required all zero",
                     dmem_req, ls_done, ls_stall, rdata_out, dmem_be, dmem_addr);
        end else pass_cnt++;
        rstn = 1'b1;
        step();
        dmem_rvalid = 1'b0;
        step();
        total_cnt++;
        if (ls_done !== 1'b0 || ls_stall !== 1'b0 || dmem_req !== 1'b0) begin
            $display("FAIL stray_rvalid: done=%b stall=%b req=%b required 0 0 0",
                     ls_done, ls_stall, dmem_req);
        end else pass_cnt++;
    endtask

    task automatic test_store_word();
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (be !== 4'b1111 || a !== 32'h100 || w !== 32'hDEADBEEF || we !== 1'b1) begin
            $display("FAIL sw_bus: be=%b addr=%h wdata=%h we=%b required 1111 00000100 deadbeef 1",
                     be, a, w, we);
        end else pass_cnt++;
        total_cnt++;
        if (s !== 3) $display("FAIL sw_stall_cycles: got %0d required 3", s);
        else pass_cnt++;
        total_cnt++;
        if (d !== 1 || da !== 3) $display("FAIL sw_done: count=%0d at=%0d required 1 at 3", d, da);
        else pass_cnt++;
        total_cnt++;
        if (rdata_out !== 32'h0) $display("FAIL sw_rdata_hold: got %h required 00000000", rdata_out);
        else pass_cnt++;
    endtask

    task automatic test_load_byte();
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (rdata_out !== 32'hFFFFFF80 || be !== 4'b1000 || a !== 32'h100 || we !== 1'b0)
            $display("FAIL lb: rdata=%h be=%b addr=%h required ffffff80 1000 00000100",
                     rdata_out, be, a);
        else pass_cnt++;
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (rdata_out !== 32'h00000080) $display("FAIL lbu: got %h required 00000080", rdata_out);
        else pass_cnt++;
    endtask

    task automatic test_half();
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        do_access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (be !== 4'b1100 || w !== 32'hABCDABCD || a !== 32'h100)
            $display("FAIL sh_bus: be=%b wdata=%h addr=%h required 1100 abcdabcd 00000100",
                     be, w, a);
        else pass_cnt++;
        total_cnt++;
        if (rdata_out !== 32'h00000080)
            $display("FAIL store_keeps_rdata: got %h required 00000080", rdata_out);
        else pass_cnt++;
        do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'hABCD1234, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (rdata_out !== 32'h0000ABCD) $display("FAIL lhu: got %h required 0000abcd", rdata_out);
        else pass_cnt++;
        do_access(1'b0, 3'b001, 32'h100, 32'h0, 32'h1234ABCD, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (rdata_out !== 32'hFFFFABCD || be !== 4'b0011)
            $display("FAIL lh_low: rdata=%h be=%b required ffffabcd 0011", rdata_out, be);
        else pass_cnt++;
        do_access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (be !== 4'b0010 || w !== 32'hA5A5A5A5 || a !== 32'h200)
            $display("FAIL sb_bus: be=%b wdata=%h addr=%h required 0010 a5a5a5a5 00000200",
                     be, w, a);
        else pass_cnt++;
    endtask

    task automatic test_gnt_stall();
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 3, 2,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (st !== 1'b1) $display("FAIL gnt_bus_stable: got %b required 1", st);
        else pass_cnt++;
        total_cnt++;
        if (s !== 8) $display("FAIL gnt_stall_cycles: got %0d required 8", s);
        else pass_cnt++;
        total_cnt++;
        if (d !== 1 || da !== 8) $display("FAIL gnt_done: count=%0d at=%0d required 1 at 8", d, da);
        else pass_cnt++;
        total_cnt++;
        if (rdata_out !== 32'h12345678) $display("FAIL gnt_lw: got %h required 12345678", rdata_out);
        else pass_cnt++;
    endtask

    task automatic test_reserved_f3();
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        do_access(1'b1, 3'b111, 32'h400, 32'h01020304, 32'h0, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (be !== 4'b1111 || w !== 32'h01020304)
            $display("FAIL f3_111_as_word: be=%b wdata=%h required 1111 01020304", be, w);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
        bit saw_req;
        saw_req = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010;
        alu_result = 32'h101; Rd2 = 32'h0;
        #1;
        total_cnt++;
        if (ls_misaligned !== 1'b1 || ls_stall !== 1'b0)
            $display("FAIL misaligned_trap: mis=%b stall=%b required 1 0", ls_misaligned, ls_stall);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dmem_req) saw_req = 1;
        end
        total_cnt++;
        if (saw_req) $display("FAIL misaligned_no_req: got %b required 0", saw_req);
        else pass_cnt++;
        ls_req = 1'b0;
        step();
`else
        int s, d, da;
        logic [3:0] be;
        logic [31:0] a, w;
        logic we, st;
        #1;
        total_cnt++;
        if (ls_misaligned !== 1'b0) $display("FAIL misaligned_tied: got %b required 0", ls_misaligned);
        else pass_cnt++;
        do_access(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0,
                  s, d, da, be, a, w, we, st);
        total_cnt++;
        if (a !== 32'h100 || d !== 1 || rdata_out !== 32'hCAFEF00D)
            $display("FAIL misaligned_truncate: addr=%h done=%0d rdata=%h required 00000100 1 cafef00d",
                     a, d, rdata_out);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid();
        int dn;
        dn = 0;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010;
        alu_result = 32'h500; dmem_rdata = 32'h55AA55AA;
        step();
        total_cnt++;
        if (dmem_req !== 1'b1) $display("FAIL abort_req_issued: got %b required 1", dmem_req);
        else pass_cnt++;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        ls_req = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        dmem_rvalid = 1'b1;
        total_cnt++;
        if (dmem_req !== 1'b0 || ls_stall !== 1'b0)
            $display("FAIL abort_idle: req=%b stall=%b required 0 0", dmem_req, ls_stall);
        else pass_cnt++;
        step();
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ls_done) dn++;
            step();
        end
        total_cnt++;
        if (dn !== 0 || rdata_out !== 32'h0)
            $display("FAIL abort_no_done: done=%0d rdata=%h required 0 00000000", dn, rdata_out);
        else pass_cnt++;
    endtask

    initial begin
        rstn = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'b0;
        alu_result = '0; Rd2 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        step();
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_gnt_stall();
        test_reserved_f3();
        test_misaligned();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
